// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite peripheral slave: register map, response codes,
// FSM states and address decode helpers.
package axil_pkg;

    localparam logic [31:0] OFF_CTRL     = 32'h00;
    localparam logic [31:0] OFF_STATUS   = 32'h04;
    localparam logic [31:0] OFF_IRQ_EN   = 32'h08;
    localparam logic [31:0] OFF_IRQ_PEND = 32'h0C;
    localparam logic [31:0] OFF_SCRATCH  = 32'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned IRQ_W = 8;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    typedef enum logic [2:0] {
        REG_CTRL, REG_STATUS, REG_IRQ_EN, REG_IRQ_PEND, REG_SCRATCH, REG_NONE
    } reg_sel_t;

    typedef struct packed {
        reg_sel_t   sel;
        logic [1:0] idx;
    } reg_dec_t;

    // byte_off must already have bits 1:0 cleared
    function automatic reg_dec_t decode(input logic [31:0] byte_off, input int unsigned num_scratch);
        reg_dec_t dec;
        dec.sel = REG_NONE;
        dec.idx = '0;
        if (byte_off == OFF_CTRL)          dec.sel = REG_CTRL;
        else if (byte_off == OFF_STATUS)   dec.sel = REG_STATUS;
        else if (byte_off == OFF_IRQ_EN)   dec.sel = REG_IRQ_EN;
        else if (byte_off == OFF_IRQ_PEND) dec.sel = REG_IRQ_PEND;
        else if (byte_off >= OFF_SCRATCH && byte_off < OFF_SCRATCH + 4 * num_scratch) begin
            dec.sel = REG_SCRATCH;
            dec.idx = 2'((byte_off - OFF_SCRATCH) >> 2);
        end
        return dec;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction

endpackage

// File: rtl/axil_irq_pend.sv
// Interrupt pending register: rising-edge detect on irq_src, write-one-to-clear,
// with a new edge taking priority over a clear in the same cycle.
module axil_irq_pend
    import axil_pkg::*;
#(
    parameter int unsigned WIDTH = IRQ_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] irq_src,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] pend
);

    logic [WIDTH-1:0] src_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            pend  <= '0;
        end else begin
            src_q <= irq_src;
            pend  <= (pend & ~clr) | (irq_src & ~src_q);
        end
    end

endmodule

// File: rtl/axil_periph_slave.sv
// AXI4-Lite peripheral slave: CTRL/STATUS/IRQ_EN/IRQ_PEND/SCRATCH registers.
// Define AXIL_SLV_WSTRB_EN to honour wstrb byte enables; otherwise all 32 bits are written.
module axil_periph_slave
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned NUM_SCRATCH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [31:0]       status_in,
    input  logic [7:0]        irq_src,
    output logic [31:0]       ctrl_out,
    output logic              irq
);

    wstate_t     wstate;
    rstate_t     rstate;
    logic        aw_open;
    logic [31:0] ctrl;
    logic [7:0]  irq_en;
    logic [7:0]  irq_pend;
    logic [31:0] scratch [NUM_SCRATCH];

    reg_dec_t    wdec, rdec;
    logic        wr_fire, rd_fire, wr_ok, rd_ok;
    logic [31:0] wmask, rd_word;
    logic [7:0]  pend_clr;

    // aw_open is low during reset and while a response is outstanding, so the
    // combinational handshake can only fire in an idle, out-of-reset cycle.
    assign awready = aw_open & awvalid & wvalid;
    assign wready  = awready;
    assign wr_fire = awready;
    assign rd_fire = arready & arvalid;

`ifdef AXIL_SLV_WSTRB_EN
    assign wmask = strb_mask(wstrb);
`else
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
    assign wmask = '1;
`endif

    always_comb begin
        wdec     = decode(32'(awaddr) & ~32'h3, NUM_SCRATCH);
        rdec     = decode(32'(araddr) & ~32'h3, NUM_SCRATCH);
        wr_ok    = (wdec.sel != REG_NONE) && (wdec.sel != REG_STATUS);
        rd_ok    = (rdec.sel != REG_NONE);
        pend_clr = (wr_fire && wdec.sel == REG_IRQ_PEND) ? (wdata[7:0] & wmask[7:0]) : '0;
        rd_word  = '0;
        case (rdec.sel)
            REG_CTRL:     rd_word = ctrl;
            REG_STATUS:   rd_word = status_in;
            REG_IRQ_EN:   rd_word = {24'h0, irq_en};
            REG_IRQ_PEND: rd_word = {24'h0, irq_pend};
            REG_SCRATCH:  rd_word = scratch[rdec.idx];
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate  <= W_IDLE;
            aw_open <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            ctrl    <= '0;
            irq_en  <= '0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wr_fire) begin
                        wstate  <= W_RESP;
                        aw_open <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        case (wdec.sel)
                            REG_CTRL:    ctrl   <= (ctrl & ~wmask) | (wdata & wmask);
                            REG_IRQ_EN:  irq_en <= (irq_en & ~wmask[7:0]) | (wdata[7:0] & wmask[7:0]);
                            REG_SCRATCH: scratch[wdec.idx] <= (scratch[wdec.idx] & ~wmask) | (wdata & wmask);
                            default: ;
                        endcase
                    end else begin
                        aw_open <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wstate  <= W_IDLE;
                        aw_open <= 1'b1;
                        bvalid  <= 1'b0;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (rd_fire) begin
                        rstate  <= R_DATA;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rdata   <= rd_ok ? rd_word : '0;
                        rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rstate  <= R_IDLE;
                        arready <= 1'b1;
                        rvalid  <= 1'b0;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    axil_irq_pend #(.WIDTH(IRQ_W)) u_irq_pend (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .clr     (pend_clr),
        .pend    (irq_pend)
    );

    assign ctrl_out = ctrl;
    assign irq      = ctrl[0] & (|(irq_pend & irq_en));

endmodule

// File: tb/tb_axil_periph_slave.sv
// Directed bench for axil_periph_slave with a register-map model and per-cycle output compare.
module tb_axil_periph_slave;

    localparam int unsigned NS = 4;

    logic        clk, rst;
    logic [8:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata, status_in, ctrl_out;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, irq;
    logic [7:0]  irq_src;

    int checks = 0;
    int errors = 0;

    axil_periph_slave #(.ADDR_W(9), .NUM_SCRATCH(NS)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .status_in(status_in), .irq_src(irq_src), .ctrl_out(ctrl_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // ---------------- register-map model ----------------
    logic        m_live, m_bv, m_rv;
    logic [1:0]  m_br, m_rr;
    logic [31:0] m_rd, m_ctrl;
    logic [7:0]  m_en, m_pend, m_prev;
    logic [31:0] m_scr [NS];

    logic [31:0] m_wa, m_ra, m_wmask, m_rval, m_new_ctrl, m_new_en, m_new_scr;
    logic        m_wacc, m_racc, m_wok, m_rok;
    logic [7:0]  m_clr;
    int          m_widx;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [31:0] msk);
        return (old & ~msk) | (nw & msk);
    endfunction

    function automatic logic in_map(input logic [31:0] a);
        return (a <= 32'h0C) || (a >= 32'h10 && a < 32'h10 + 4 * NS);
    endfunction

    always_comb begin
        m_wa   = {23'h0, awaddr[8:2], 2'b00};
        m_ra   = {23'h0, araddr[8:2], 2'b00};
`ifdef AXIL_SLV_WSTRB_EN
        m_wmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
`else
        m_wmask = 32'hFFFF_FFFF;
`endif
        m_wacc = m_live && !m_bv && awvalid && wvalid;
        m_racc = m_live && !m_rv && arvalid;
        m_wok  = in_map(m_wa) && (m_wa != 32'h04);
        m_rok  = in_map(m_ra);
        m_widx = (m_wa >= 32'h10) ? int'((m_wa - 32'h10) / 4) : 0;
        m_clr  = (m_wacc && m_wa == 32'h0C) ? (wdata[7:0] & m_wmask[7:0]) : 8'h00;
        m_new_ctrl = merge(m_ctrl, wdata, m_wmask);
        m_new_en   = merge({24'h0, m_en}, wdata, m_wmask);
        m_new_scr  = (m_widx < NS) ? merge(m_scr[m_widx], wdata, m_wmask) : 32'h0;
        m_rval = 32'h0;
        if (m_ra == 32'h00)      m_rval = m_ctrl;
        else if (m_ra == 32'h04) m_rval = status_in;
        else if (m_ra == 32'h08) m_rval = {24'h0, m_en};
        else if (m_ra == 32'h0C) m_rval = {24'h0, m_pend};
        else if (m_rok)          m_rval = m_scr[(m_ra - 32'h10) / 4];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_live <= 1'b0; m_bv <= 1'b0; m_rv <= 1'b0; m_br <= 2'b00; m_rr <= 2'b00;
            m_rd <= 32'h0; m_ctrl <= 32'h0; m_en <= 8'h0; m_pend <= 8'h0; m_prev <= 8'h0;
            for (int i = 0; i < NS; i++) m_scr[i] <= 32'h0;
        end else begin
            m_live <= 1'b1;
            m_prev <= irq_src;
            m_pend <= (m_pend & ~m_clr) | (irq_src & ~m_prev);
            if (m_wacc) begin
                m_bv <= 1'b1;
                m_br <= m_wok ? 2'b00 : 2'b10;
                if (m_wok) begin
                    if (m_wa == 32'h00)      m_ctrl <= m_new_ctrl;
                    else if (m_wa == 32'h08) m_en <= m_new_en[7:0];
                    else if (m_wa >= 32'h10) m_scr[m_widx] <= m_new_scr;
                end
            end else if (m_bv && bready) begin
                m_bv <= 1'b0;
            end
            if (m_racc) begin
                m_rv <= 1'b1;
                m_rd <= m_rok ? m_rval : 32'h0;
                m_rr <= m_rok ? 2'b00 : 2'b10;
            end else if (m_rv && rready) begin
                m_rv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_awready", awready, m_live && !m_bv && awvalid && wvalid);
            chk("cmp_wready", wready, m_live && !m_bv && awvalid && wvalid);
            chk("cmp_arready", arready, m_live && !m_rv);
            chk("cmp_bvalid", bvalid, m_bv);
            chk("cmp_rvalid", rvalid, m_rv);
            if (m_bv) chk("cmp_bresp", bresp, m_br);
            if (m_rv) begin
                chk("cmp_rdata", rdata, m_rd);
                chk("cmp_rresp", rresp, m_rr);
            end
            chk("cmp_ctrl_out", ctrl_out, m_ctrl);
            chk("cmp_irq", irq, m_ctrl[0] & (|(m_pend & m_en)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp_r, input bit wait_b, input string name);
        bit got;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if (awready) got = 1'b1;
        end
        if (!got) tmo({name, "_aw"});
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk({name, "_bvalid"}, bvalid, 1'b1);
        chk({name, "_bresp"}, bresp, exp_r);
        if (wait_b) begin
            got = 1'b0;
            for (int i = 0; i < 32 && !got; i++) begin
                @(negedge clk);
                if (!bvalid) got = 1'b1;
            end
            if (!got) tmo({name, "_bdone"});
        end
    endtask

    task automatic axi_read(input logic [8:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                            input string name);
        bit got;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if (arready) got = 1'b1;
        end
        if (!got) tmo({name, "_ar"});
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk({name, "_rvalid"}, rvalid, 1'b1);
        chk({name, "_rdata"}, rdata, exp_d);
        chk({name, "_rresp"}, rresp, exp_r);
        got = 1'b0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if (!rvalid) got = 1'b1;
        end
        if (!got) tmo({name, "_rdone"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1; status_in = 32'h1234_5678; irq_src = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ctrl", ctrl_out, 32'h0);
        chk("rst_irq", irq, 1'b0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_arready_before_edge", arready, 1'b0);
        @(negedge clk);
        chk("rel_arready", arready, 1'b1);

        axi_write(9'h010, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1, "wr_scr0");
        axi_read(9'h010, 32'hDEAD_BEEF, 2'b00, "rd_scr0");
        axi_read(9'h013, 32'hDEAD_BEEF, 2'b00, "rd_scr0_lowbits");
        axi_read(9'h004, 32'h1234_5678, 2'b00, "rd_status");

        axi_read(9'h040, 32'h0, 2'b10, "rd_undec");
        axi_write(9'h004, 32'h0BAD_0BAD, 4'hF, 2'b10, 1'b1, "wr_status");
        axi_read(9'h004, 32'h1234_5678, 2'b00, "rd_status_after");
        axi_write(9'h020, 32'h5555_5555, 4'hF, 2'b10, 1'b1, "wr_undec");
        axi_read(9'h020, 32'h0, 2'b10, "rd_scr_oob");
        axi_write(9'h000, 32'hA5A5_0000, 4'hF, 2'b00, 1'b1, "wr_ctrl");
        axi_read(9'h000, 32'hA5A5_0000, 2'b00, "rd_ctrl");
        chk("ctrl_out_lit", ctrl_out, 32'hA5A5_0000);

        // write response back-pressure
        bready = 1'b0;
        axi_write(9'h018, 32'hCAFE_0001, 4'hF, 2'b00, 1'b0, "wr_bp1");
        @(posedge clk); #1;
        awaddr = 9'h01C; wdata = 32'hCAFE_0002; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_bvalid", bvalid, 1'b1);
            chk("bp_bresp", bresp, 2'b00);
            chk("bp_awready", awready, 1'b0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if (awready) got = 1'b1;
        end
        if (!got) tmo("bp_second_aw");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bp2_bvalid", bvalid, 1'b1);
        @(negedge clk);
        axi_read(9'h018, 32'hCAFE_0001, 2'b00, "rd_bp1");
        axi_read(9'h01C, 32'hCAFE_0002, 2'b00, "rd_bp2");

        // interrupts
        axi_write(9'h008, 32'hFFFF_FF01, 4'hF, 2'b00, 1'b1, "wr_irq_en");
        axi_read(9'h008, 32'h0000_0001, 2'b00, "rd_irq_en");
        axi_write(9'h000, 32'h0000_0001, 4'hF, 2'b00, 1'b1, "wr_ctrl_en");
        chk("irq_idle", irq, 1'b0);
        @(posedge clk); #1; irq_src = 8'h01;
        @(posedge clk); #1; irq_src = 8'h00;
        @(negedge clk);
        chk("irq_set", irq, 1'b1);
        axi_read(9'h00C, 32'h0000_0001, 2'b00, "rd_pend");
        axi_write(9'h00C, 32'h0000_0001, 4'hF, 2'b00, 1'b1, "wr_pend_clr");
        chk("irq_cleared", irq, 1'b0);
        axi_read(9'h00C, 32'h0, 2'b00, "rd_pend_clr");
        @(posedge clk); #1;
        awaddr = 9'h00C; wdata = 32'h0000_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        irq_src = 8'h01;
        @(negedge clk);
        chk("setclr_awready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; irq_src = 8'h00;
        @(negedge clk);
        chk("setclr_irq", irq, 1'b1);
        axi_read(9'h00C, 32'h0000_0001, 2'b00, "rd_pend_setclr");

        // byte strobes
        axi_write(9'h010, 32'hFFFF_FFFF, 4'hF, 2'b00, 1'b1, "wr_scr0_ones");
        axi_write(9'h010, 32'h0000_0000, 4'b0010, 2'b00, 1'b1, "wr_scr0_strb");
`ifdef AXIL_SLV_WSTRB_EN
        axi_read(9'h010, 32'hFFFF_00FF, 2'b00, "rd_scr0_strb");
`else
        axi_read(9'h010, 32'h0000_0000, 2'b00, "rd_scr0_strb");
`endif

        // concurrent read and write of the same register
        axi_write(9'h014, 32'h1111_1111, 4'hF, 2'b00, 1'b1, "wr_scr1");
        @(posedge clk); #1;
        awaddr = 9'h014; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 9'h014; arvalid = 1'b1;
        @(negedge clk);
        chk("conc_awready", awready, 1'b1);
        chk("conc_arready", arready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("conc_rdata_prewrite", rdata, 32'h1111_1111);
        chk("conc_bvalid", bvalid, 1'b1);
        @(negedge clk);
        axi_read(9'h014, 32'h2222_2222, 2'b00, "rd_scr1_post");

        // reset with both responses pending
        bready = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        awaddr = 9'h018; wdata = 32'h7777_7777; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 9'h010; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_bvalid", bvalid, 1'b1);
        chk("pre_rst_rvalid", rvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_ctrl", ctrl_out, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bready = 1'b1; rready = 1'b1;
        axi_read(9'h000, 32'h0, 2'b00, "post_rst_ctrl");
        axi_read(9'h008, 32'h0, 2'b00, "post_rst_irq_en");
        axi_read(9'h00C, 32'h0, 2'b00, "post_rst_pend");
        for (int k = 0; k < 4; k++) begin
            logic [8:0] a;
            a = 9'h010 + 9'(4 * k);
            axi_read(a, 32'h0, 2'b00, "post_rst_scratch");
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
